health_controller: RTL
======================

// Module: health_controller
// PURPOSE
//  Multi-player, parametrised health/lives tracker; successor to the single-player lives counter.
//  Per player: lives, damage with variable amount, heal pickups, post-hit invulnerability window.
//  Flags death per player and game-over. Sits between collision detection and score/display/FSM logic.
// PARAMETERS
//  N_PLAYERS     2    number of independent player channels (1..8)
//  LIVES_W       3    width of each lives counter
//  MAX_LIVES     5    reset/restart and heal ceiling value (<= 2**LIVES_W-1)
//  DMG_W         2    width of per-player damage amount
//  COOLDOWN      20   invulnerability length, in game_en ticks (>=1, fits 8 bits)
//  REGEN_PERIOD  64   game_en ticks per regenerated life (used only with HEALTH_REGEN_EN)
// PORTS
//  clk        in   1                  system clock
//  rst        in   1                  async reset, active-low
//  game_en    in   1                  game tick strobe; all state advances only when high
//  restart    in   1                  sync re-init of all channels (acts regardless of game_en)
//  hit        in   N_PLAYERS          per-player collision, sampled on game_en
//  dmg        in   N_PLAYERS*DMG_W    damage per player, slice i = [i*DMG_W +: DMG_W]
//  heal       in   N_PLAYERS          per-player +1 life pickup, sampled on game_en
//  lives      out  N_PLAYERS*LIVES_W  registered lives per player
//  invuln     out  N_PLAYERS          1 while player in cooldown
//  is_dead    out  N_PLAYERS          lives==0 (combinational from lives)
//  hit_ack    out  N_PLAYERS          1-cycle pulse when damage actually applied
//  game_over  out  1                  registered; 1 when all players dead
// BEHAVIOUR
//  - Reset: lives=MAX_LIVES all, invuln=0, hit_ack=0, game_over=0, timers=0, state ALIVE.
//  - restart: same values as reset, next clk edge; priority over all other inputs.
//  - Per-channel FSM, transitions only on game_en:
//    ALIVE : hit && dmg!=0 -> lives=sat0(lives-dmg); if result 0 -> DEAD else INVULN, timer=COOLDOWN.
//            hit && dmg==0 -> ignored, no hit_ack.
//    INVULN: hit ignored; timer decrements; timer==1 -> ALIVE (exactly COOLDOWN ticks invulnerable).
//    DEAD  : absorbing until rst/restart; hit and heal ignored; invuln=0.
//  - Damage saturates at 0 (dmg > lives -> 0, no wrap). hit_ack=1 for one clk on application.
//  - heal in ALIVE/INVULN: lives=min(lives+1, MAX_LIVES); does not alter timer.
//  - hit and heal same tick in ALIVE: result = sat(lives - dmg + 1), clamped [0,MAX_LIVES]; 0 -> DEAD.
//  - Latency: lives/invuln/hit_ack update 1 clk after sampled game_en; game_over 1 clk after last is_dead.
//  - Channels fully independent; no cross-player arbitration.
//  - rst mid-cooldown: timer cleared, invuln drops immediately (async).
// CONFIGURATION
//  HEALTH_REGEN_EN defined: per-channel regen counter counts game_en ticks in ALIVE with lives<MAX_LIVES;
//    at REGEN_PERIOD adds 1 life, counter clears; counter clears on any applied hit, held in INVULN/DEAD.
//    Regen and heal on same tick add 1 total (no double).
//  Undefined: no regen logic, lives change only by hit/heal.
// STRUCTURE
//  Shared header game_defs.vh: FSM state encodings (ST_ALIVE, ST_INVULN, ST_DEAD), default MAX_LIVES,
//    COOLDOWN constants reused by display/score blocks.
//  Sub-module health_channel: one player's FSM, timer, lives, regen; generate-loop N_PLAYERS instances.
//  Top: slicing, game_over register.
// TESTING
//  1 rst low then release, N=2 -> lives=5,5; invuln=0; game_over=0.
//  2 P0 hit dmg=2 on game_en -> lives0=3, hit_ack0 1 clk, invuln0 for exactly 20 ticks; hit at tick 10 ignored.
//  3 P1 lives=1, hit dmg=3 -> lives1=0, no wrap, is_dead1=1, later heal ignored.
//  4 Both players killed -> game_over=1 one clk after second death; restart -> all back to 5, game_over=0.
//  5 P0 lives=5 heal -> stays 5; lives=3 hit dmg=1 + heal same tick -> 3, invuln0=1.
//  6 HEALTH_REGEN_EN, REGEN_PERIOD=4: lives=3 ALIVE -> 4 after 4 ticks; hit at tick 3 restarts count.

Source files
------------

// File: rtl/health_controller_pkg.sv
// Shared health/lives definitions: channel state encodings and default constants.
// Display and score blocks import the same encodings.
package health_controller_pkg;

  typedef enum logic [1:0] {
    ST_ALIVE  = 2'd0,
    ST_INVULN = 2'd1,
    ST_DEAD   = 2'd2
  } health_state_e;

  localparam int DEF_MAX_LIVES = 5;
  localparam int DEF_COOLDOWN  = 20;
  localparam int TIMER_W       = 8;

endpackage

// File: rtl/health_channel.sv
// One player's health FSM: lives, damage/heal, invulnerability timer.
// Optional life regeneration is built when HEALTH_REGEN_EN is defined.
module health_channel
  import health_controller_pkg::*;
#(
  parameter int LIVES_W      = 3,
  parameter int MAX_LIVES    = DEF_MAX_LIVES,
  parameter int DMG_W        = 2,
  parameter int COOLDOWN     = DEF_COOLDOWN,
  parameter int REGEN_PERIOD = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               game_en,
  input  logic               restart,
  input  logic               hit,
  input  logic [DMG_W-1:0]   dmg,
  input  logic               heal,
  output logic [LIVES_W-1:0] lives,
  output logic               invuln,
  output logic               hit_ack
);

  health_state_e      state;
  logic [TIMER_W-1:0] timer;
  logic               apply;
  logic               inc;
  logic               regen_tick;
  int                 sum;

`ifdef HEALTH_REGEN_EN
  localparam int RC_W = $clog2(REGEN_PERIOD + 1);
  logic [RC_W-1:0] regen_cnt;

  assign regen_tick = game_en && (state == ST_ALIVE) && !apply &&
                      (lives < LIVES_W'(MAX_LIVES)) &&
                      (regen_cnt == RC_W'(REGEN_PERIOD - 1));

  // Counts only while ALIVE and below the ceiling; applied hits restart it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      regen_cnt <= '0;
    else if (restart)
      regen_cnt <= '0;
    else if (game_en && state == ST_ALIVE) begin
      if (apply || regen_tick || lives >= LIVES_W'(MAX_LIVES))
        regen_cnt <= '0;
      else
        regen_cnt <= regen_cnt + 1'b1;
    end
  end
`else
  assign regen_tick = 1'b0;
`endif

  // Heal and regen on the same tick merge into a single +1.
  always_comb begin
    apply = (state == ST_ALIVE) && hit && (dmg != '0);
    inc   = (state != ST_DEAD) && (heal || regen_tick);
    sum   = int'(lives) + (inc ? 1 : 0) - (apply ? int'(dmg) : 0);
    if (sum < 0)
      sum = 0;
    else if (sum > MAX_LIVES)
      sum = MAX_LIVES;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_ALIVE;
      lives   <= LIVES_W'(MAX_LIVES);
      timer   <= '0;
      invuln  <= 1'b0;
      hit_ack <= 1'b0;
    end else if (restart) begin
      state   <= ST_ALIVE;
      lives   <= LIVES_W'(MAX_LIVES);
      timer   <= '0;
      invuln  <= 1'b0;
      hit_ack <= 1'b0;
    end else begin
      hit_ack <= 1'b0;
      if (game_en) begin
        lives <= LIVES_W'(sum);
        case (state)
          ST_ALIVE: if (apply) begin
            hit_ack <= 1'b1;
            if (sum == 0) begin
              state  <= ST_DEAD;
              invuln <= 1'b0;
            end else begin
              state  <= ST_INVULN;
              timer  <= TIMER_W'(COOLDOWN);
              invuln <= 1'b1;
            end
          end
          // timer==1 on entry is the last invulnerable tick.
          ST_INVULN: if (timer == TIMER_W'(1)) begin
            state  <= ST_ALIVE;
            timer  <= '0;
            invuln <= 1'b0;
          end else begin
            timer <= timer - 1'b1;
          end
          default: invuln <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: rtl/health_controller.sv
// Multi-player health tracker: one health_channel per player plus game_over register.
// Define HEALTH_REGEN_EN to build per-channel life regeneration.
module health_controller
  import health_controller_pkg::*;
#(
  parameter int N_PLAYERS    = 2,
  parameter int LIVES_W      = 3,
  parameter int MAX_LIVES    = DEF_MAX_LIVES,
  parameter int DMG_W        = 2,
  parameter int COOLDOWN     = DEF_COOLDOWN,
  parameter int REGEN_PERIOD = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           game_en,
  input  logic                           restart,
  input  logic [N_PLAYERS-1:0]           hit,
  input  logic [N_PLAYERS*DMG_W-1:0]     dmg,
  input  logic [N_PLAYERS-1:0]           heal,
  output logic [N_PLAYERS*LIVES_W-1:0]   lives,
  output logic [N_PLAYERS-1:0]           invuln,
  output logic [N_PLAYERS-1:0]           is_dead,
  output logic [N_PLAYERS-1:0]           hit_ack,
  output logic                           game_over
);

  for (genvar i = 0; i < N_PLAYERS; i++) begin : g_ch
    health_channel #(
      .LIVES_W     (LIVES_W),
      .MAX_LIVES   (MAX_LIVES),
      .DMG_W       (DMG_W),
      .COOLDOWN    (COOLDOWN),
      .REGEN_PERIOD(REGEN_PERIOD)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .game_en(game_en),
      .restart(restart),
      .hit    (hit[i]),
      .dmg    (dmg[i*DMG_W +: DMG_W]),
      .heal   (heal[i]),
      .lives  (lives[i*LIVES_W +: LIVES_W]),
      .invuln (invuln[i]),
      .hit_ack(hit_ack[i])
    );
    assign is_dead[i] = (lives[i*LIVES_W +: LIVES_W] == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      game_over <= 1'b0;
    else if (restart)
      game_over <= 1'b0;
    else
      game_over <= &is_dead;
  end

endmodule
